pc_target_table: RTL and testbench

- Programmable branch-target table for the fetch stage. Replaces the fixed, initial-block-loaded target LUT.
- Depth and width are parametrised.
- Each entry holds a valid bit, a mode bit (absolute target or PC-relative offset) and a D-bit value.
- Lookups are registered, with one-cycle latency. Misses fall through to PC+1, and a saturating miss counter is kept for debug.

---
 rtl/pc_target_table_if.sv | 30 +++
 rtl/pc_target_table.sv | 88 ++++++++
 tb/tb_pc_target_table.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_target_table_if.sv
// Lookup/programming bus for pc_target_table.
// Master drives writes and lookups; slave returns the registered response.
interface pc_target_table_if #(
  parameter int D  = 10,
  parameter int A  = 4,
  parameter int CW = 8
);
  logic          clr;
  logic          wr_en;
  logic [A-1:0]  wr_addr;
  logic [D-1:0]  wr_data;
  logic          wr_rel;
  logic          rd_req;
  logic [A-1:0]  rd_addr;
  logic [D-1:0]  pc;
  logic          resp_valid;
  logic [D-1:0]  target;
  logic          hit;
  logic [CW-1:0] miss_cnt;

  modport master (
    output clr, wr_en, wr_addr, wr_data, wr_rel, rd_req, rd_addr, pc,
    input  resp_valid, target, hit, miss_cnt
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_data, wr_rel, rd_req, rd_addr, pc,
    output resp_valid, target, hit, miss_cnt
  );
endinterface

// File: rtl/pc_target_table.sv
// Programmable branch-target table: absolute or PC-relative entries,
// registered one-cycle lookup with write-first bypass and a saturating miss counter.
module pc_target_table #(
  parameter int D  = 10,
  parameter int A  = 4,
  parameter int CW = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  pc_target_table_if.slave bus
);
  localparam int DEPTH = 2 ** A;

  logic          valid_q [DEPTH];
  logic          mode_q  [DEPTH];
  logic [D-1:0]  value_q [DEPTH];

  logic          wr_match;
  logic          lk_valid;
  logic          lk_mode;
  logic [D-1:0]  lk_value;
  logic [D-1:0]  lk_target;
  logic          cnt_sat;

  // Table storage: clear is applied first, so a same-cycle write survives it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        mode_q[i]  <= 1'b0;
        value_q[i] <= '0;
      end
    end else begin
      if (bus.clr) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (bus.wr_en) begin
        valid_q[bus.wr_addr] <= 1'b1;
        mode_q[bus.wr_addr]  <= bus.wr_rel;
        value_q[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Lookup sees the table as it will be after this cycle's clr/write.
  always_comb begin
    wr_match = bus.wr_en && (bus.wr_addr == bus.rd_addr);
    lk_valid = 1'b0;
    lk_mode  = mode_q[bus.rd_addr];
    lk_value = value_q[bus.rd_addr];
    if (wr_match) begin
      lk_valid = 1'b1;
      lk_mode  = bus.wr_rel;
      lk_value = bus.wr_data;
    end else if (!bus.clr) begin
      lk_valid = valid_q[bus.rd_addr];
    end
  end

  always_comb begin
    lk_target = bus.pc + D'(1);
    if (lk_valid) begin
      lk_target = lk_mode ? (bus.pc + lk_value) : lk_value;
    end
  end

  assign cnt_sat = (bus.miss_cnt == '1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.resp_valid <= 1'b0;
      bus.target     <= '0;
      bus.hit        <= 1'b0;
      bus.miss_cnt   <= '0;
    end else begin
      bus.resp_valid <= bus.rd_req;
      if (bus.rd_req) begin
        bus.target <= lk_target;
        bus.hit    <= lk_valid;
        if (!lk_valid && !cnt_sat) begin
          bus.miss_cnt <= bus.miss_cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_target_table.sv
// Randomized and directed checks of pc_target_table against a table model,
// using two instances (miss counter widths 8 and 2) on identical stimulus.
module tb_pc_target_table;
  logic Clk = 1'b0;
  logic Reset = 1'b1;

  logic       clr = 0, wr_en = 0, wr_rel = 0, rd_req = 0;
  logic [3:0] wr_addr = 0, rd_addr = 0;
  logic [9:0] wr_data = 0, pc = 0;

  int n_chk = 0;
  int n_fail = 0;
  bit started = 0;

  pc_target_table_if #(.D(10), .A(4), .CW(8)) bus8 ();
  pc_target_table_if #(.D(10), .A(4), .CW(2)) bus2 ();

  assign bus8.clr = clr;      assign bus2.clr = clr;
  assign bus8.wr_en = wr_en;  assign bus2.wr_en = wr_en;
  assign bus8.wr_addr = wr_addr; assign bus2.wr_addr = wr_addr;
  assign bus8.wr_data = wr_data; assign bus2.wr_data = wr_data;
  assign bus8.wr_rel = wr_rel;   assign bus2.wr_rel = wr_rel;
  assign bus8.rd_req = rd_req;   assign bus2.rd_req = rd_req;
  assign bus8.rd_addr = rd_addr; assign bus2.rd_addr = rd_addr;
  assign bus8.pc = pc;           assign bus2.pc = pc;

  pc_target_table #(.D(10), .A(4), .CW(8)) dut8 (.Clk(Clk), .Reset(Reset), .bus(bus8));
  pc_target_table #(.D(10), .A(4), .CW(2)) dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));

  always #5 Clk = ~Clk;

  // Reference model: plain arrays plus expected outputs.
  bit m_valid [16];
  bit m_mode  [16];
  int m_val   [16];
  int exp_rv, exp_hit, exp_tgt, exp_mc8, exp_mc2;

  function automatic int lk_hit();
    if (wr_en && wr_addr == rd_addr) return 1;
    if (clr) return 0;
    return int'(m_valid[rd_addr]);
  endfunction

  function automatic int lk_tgt();
    bit md;
    int v;
    if (wr_en && wr_addr == rd_addr) begin
      md = wr_rel; v = int'(wr_data);
    end else begin
      md = m_mode[rd_addr]; v = m_val[rd_addr];
    end
    if (lk_hit() == 0) return (int'(pc) + 1) % 1024;
    if (md) return (int'(pc) + v) % 1024;
    return v;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] <= 0; m_mode[i] <= 0; m_val[i] <= 0;
      end
      exp_rv <= 0; exp_hit <= 0; exp_tgt <= 0; exp_mc8 <= 0; exp_mc2 <= 0;
    end else begin
      if (clr)
        for (int i = 0; i < 16; i++) m_valid[i] <= 0;
      if (wr_en) begin
        m_valid[wr_addr] <= 1;
        m_mode[wr_addr]  <= wr_rel;
        m_val[wr_addr]   <= int'(wr_data);
      end
      exp_rv <= int'(rd_req);
      if (rd_req) begin
        exp_hit <= lk_hit();
        exp_tgt <= lk_tgt();
        if (lk_hit() == 0) begin
          exp_mc8 <= (exp_mc8 < 255) ? exp_mc8 + 1 : 255;
          exp_mc2 <= (exp_mc2 < 3) ? exp_mc2 + 1 : 3;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (started && !Reset) begin
      chk("rv8",  32'(bus8.resp_valid), exp_rv);
      chk("hit8", 32'(bus8.hit),        exp_hit);
      chk("tgt8", 32'(bus8.target),     exp_tgt);
      chk("mc8",  32'(bus8.miss_cnt),   exp_mc8);
      chk("rv2",  32'(bus2.resp_valid), exp_rv);
      chk("hit2", 32'(bus2.hit),        exp_hit);
      chk("tgt2", 32'(bus2.target),     exp_tgt);
      chk("mc2",  32'(bus2.miss_cnt),   exp_mc2);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; wr_en = 0; rd_req = 0;
  endtask

  task automatic wr(input int a, input int d, input bit rel);
    wr_en = 1; wr_addr = 4'(a); wr_data = 10'(d); wr_rel = rel;
  endtask

  task automatic rd(input int a, input int p);
    rd_req = 1; rd_addr = 4'(a); pc = 10'(p);
  endtask

  task automatic resp(input string name, input int h, input int t);
    chk({name, "_rv"},  32'(bus8.resp_valid), 1);
    chk({name, "_hit"}, 32'(bus8.hit), h);
    chk({name, "_tgt"}, 32'(bus8.target), t);
  endtask

  int mc_seq [5] = '{1, 2, 3, 3, 3};

  initial begin
    tick(); tick();
    Reset = 0;
    started = 1;
    chk("rst_rv",  32'(bus8.resp_valid), 0);
    chk("rst_tgt", 32'(bus8.target), 0);
    chk("rst_hit", 32'(bus8.hit), 0);
    chk("rst_mc",  32'(bus8.miss_cnt), 0);

    rd(3, 40); tick(); idle();
    resp("miss3", 0, 41);
    chk("miss3_mc", 32'(bus8.miss_cnt), 1);

    wr(2, 80, 0); tick(); idle();
    rd(2, 5); tick(); idle();
    resp("abs2", 1, 80);
    wr(5, 10'h3FB, 1); tick(); idle();
    rd(5, 4); tick();
    resp("rel_wrap", 1, 10'h3FF);
    rd(5, 20); tick(); idle();
    resp("rel_pos", 1, 15);

    wr(7, 113, 0); rd(7, 0); tick(); idle();
    resp("bypass7", 1, 113);
    clr = 1; rd(2, 50); tick(); idle();
    resp("clr_rd2", 0, 51);

    wr(2, 80, 0); tick(); wr(7, 113, 0); tick(); idle();
    clr = 1; wr(1, 9, 0); tick(); idle();
    rd(1, 100); tick();
    resp("clrwr1", 1, 9);
    rd(2, 100); tick();
    resp("clrwr2", 0, 101);
    rd(7, 200); tick(); idle();
    resp("clrwr7", 0, 201);

    Reset = 1; tick(); Reset = 0;
    for (int i = 0; i < 5; i++) begin
      rd(9, i * 3); tick();
      chk("sat_mc2", 32'(bus2.miss_cnt), mc_seq[i]);
    end
    idle(); clr = 1; tick(); idle(); tick();
    chk("clr_mc2", 32'(bus2.miss_cnt), 3);
    chk("clr_mc8", 32'(bus8.miss_cnt), 5);
    #2 Reset = 1;
    #1;
    chk("async_mc2", 32'(bus2.miss_cnt), 0);
    chk("async_mc8", 32'(bus8.miss_cnt), 0);
    chk("async_rv",  32'(bus8.resp_valid), 0);
    chk("async_hit", 32'(bus8.hit), 0);
    tick(); Reset = 0;

    wr(2, 80, 0); tick(); idle();
    rd(2, 7);
    #2 Reset = 1;
    idle();
    tick(); Reset = 0;
    tick();
    chk("rst_drop_rv", 32'(bus8.resp_valid), 0);
    rd(2, 7); tick(); idle();
    resp("after_rst2", 0, 8);

    for (int i = 0; i < 3000; i++) begin
      clr     = ($urandom_range(15) == 0);
      wr_en   = $urandom_range(1);
      wr_addr = 4'($urandom_range(15));
      wr_data = 10'($urandom);
      wr_rel  = $urandom_range(1);
      rd_req  = ($urandom_range(3) != 0);
      rd_addr = $urandom_range(3) == 0 ? wr_addr : 4'($urandom_range(15));
      pc      = 10'($urandom);
      tick();
    end
    idle(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
